// File: rtl/buck_gate_ctrl_pkg.sv
// Shared types, default widths and the ramp saturation helper for the
// buck gate-drive controller.
package buck_gate_ctrl_pkg;

  localparam int CNT_W_DEF = 16;
  localparam int DT_W_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SOFT_START = 2'd1,
    RUN        = 2'd2,
    FAULT      = 2'd3
  } state_t;

  // min(a + b, lim) with a carry bit so the sum never wraps.
  function automatic logic [31:0] sat_add_min(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) return lim;
    return sum[31:0];
  endfunction

endpackage

// File: rtl/deadtime_gen.sv
// Turns the raw gate into two non-overlapping switch commands, holding both
// low for dt_q cycles after every gate edge.
module deadtime_gen
  import buck_gate_ctrl_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            g,
  input  logic            active,
  input  logic [DT_W-1:0] dt_q,
  output logic            sw1,
  output logic            sw2
);

  logic            g_prev_q, g_prev_d;
  logic [DT_W-1:0] dt_cnt_q, dt_cnt_d;
  logic            sw1_q, sw1_d;
  logic            sw2_q, sw2_d;
  logic [DT_W-1:0] dt_eff;
  logic            settled;

  always_comb begin
    g_prev_d = g;
    // An edge restarts the count in the same cycle so the first both-off
    // cycle lands immediately after the edge.
    dt_eff   = (g != g_prev_q) ? '0 : dt_cnt_q;
    settled  = (dt_eff >= dt_q);
    dt_cnt_d = settled ? dt_eff : dt_eff + 1'b1;
    sw1_d    = g & settled;
    sw2_d    = ~g & settled & active;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_prev_q <= 1'b0;
      dt_cnt_q <= '0;
      sw1_q    <= 1'b0;
      sw2_q    <= 1'b0;
    end else begin
      g_prev_q <= g_prev_d;
      dt_cnt_q <= dt_cnt_d;
      sw1_q    <= sw1_d;
      sw2_q    <= sw2_d;
    end
  end

  assign sw1 = sw1_q;
  assign sw2 = sw2_q;

endmodule

// File: rtl/buck_gate_ctrl.sv
// Complementary PWM gate controller: period counter, soft-start duty ramp,
// shadowed settings and latched fault shutdown feeding the dead-time stage.
module buck_gate_ctrl
  import buck_gate_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DT_W  = DT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [DT_W-1:0]  dead_time,
  input  logic [CNT_W-1:0] ss_step,
  input  logic             fault,
  output logic             sw1,
  output logic             sw2,
  output logic             cycle_start,
  output logic             ss_done,
  output logic [1:0]       state
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] ramp_q, ramp_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [DT_W-1:0]  dt_q, dt_d;

  logic [CNT_W-1:0] period_in, duty_in, step_in, d_eff;
  logic             running, wrap, active, g;

  always_comb begin
    period_in = (period < CNT_W'(2)) ? CNT_W'(2) : period;
    duty_in   = (duty > period_in) ? period_in : duty;
    step_in   = (ss_step == '0) ? CNT_W'(1) : ss_step;
    running   = (state_q == SOFT_START) || (state_q == RUN);
    wrap      = running && (cnt_q == period_q - CNT_W'(1));
    d_eff     = (state_q == RUN) ? duty_q : ramp_q;
    // Gating with the leave conditions drops both switches on the same edge
    // that the FSM leaves the active states.
    active    = running && en && !fault;
    g         = active && (cnt_q < d_eff);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ramp_d   = ramp_q;
    period_d = period_q;
    duty_d   = duty_q;
    dt_d     = dt_q;
    if (fault) begin
      state_d = FAULT;
      cnt_d   = '0;
    end else begin
      case (state_q)
        FAULT: begin
          cnt_d = '0;
          if (!en) state_d = IDLE;
        end
        IDLE: begin
          cnt_d = '0;
          if (en) begin
            state_d  = SOFT_START;
            period_d = period_in;
            duty_d   = duty_in;
            dt_d     = dead_time;
            ramp_d   = CNT_W'(sat_add_min(32'd0, 32'(step_in), 32'(duty_in)));
          end
        end
        default: begin
          if (!en) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (wrap) begin
            cnt_d    = '0;
            period_d = period_in;
            duty_d   = duty_in;
            dt_d     = dead_time;
            if (state_q == SOFT_START) begin
              if (ramp_q >= duty_q) state_d = RUN;
              ramp_d = CNT_W'(sat_add_min(32'(ramp_q), 32'(step_in), 32'(duty_in)));
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ramp_q   <= '0;
      period_q <= '0;
      duty_q   <= '0;
      dt_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ramp_q   <= ramp_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      dt_q     <= dt_d;
    end
  end

  deadtime_gen #(.DT_W(DT_W)) u_deadtime (
    .clk    (clk),
    .rst    (rst),
    .g      (g),
    .active (active),
    .dt_q   (dt_q),
    .sw1    (sw1),
    .sw2    (sw2)
  );

  assign cycle_start = running && (cnt_q == '0);
  assign ss_done     = (state_q == RUN);
  assign state       = state_q;

endmodule

// File: tb/tb_buck_gate_ctrl.sv
// Directed bench for buck_gate_ctrl: steady-state vector table plus
// cycle-exact sequences for soft start, shadowing, fault and reset.
module tb_buck_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, fault;
  logic [15:0] period, duty, ss_step;
  logic [7:0]  dead_time;
  logic        sw1, sw2, cycle_start, ss_done;
  logic [1:0]  state;

  int total = 0;
  int bad = 0;
  int overlap = 0;

  typedef struct {
    int p; int d; int dt; int s; int pe; int exp_sw1; int exp_sw2;
  } vec_t;
  vec_t vecs[8];

  buck_gate_ctrl dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .duty(duty),
    .dead_time(dead_time), .ss_step(ss_step), .fault(fault),
    .sw1(sw1), .sw2(sw2), .cycle_start(cycle_start), .ss_done(ss_done),
    .state(state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (sw1 && sw2) overlap++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; fault = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic start(input int p, input int d, input int dt, input int s);
    do_reset();
    period = 16'(p); duty = 16'(d); dead_time = 8'(dt); ss_step = 16'(s);
    en = 1'b1;
    step();
  endtask

  initial begin
    int c1, c2, cs, wa, wb;
    int w[6];
    int exp_w[6];
    exp_w = '{1, 2, 3, 4, 4, 4};

    vecs[0] = '{10, 5, 0, 5, 10, 5, 5};
    vecs[1] = '{10, 5, 2, 5, 10, 3, 3};
    vecs[2] = '{10, 0, 2, 1, 10, 0, 10};
    vecs[3] = '{10, 12, 3, 20, 10, 10, 0};
    vecs[4] = '{1, 1, 0, 1, 2, 1, 1};
    vecs[5] = '{8, 2, 1, 0, 8, 1, 5};
    vecs[6] = '{20, 15, 4, 7, 20, 11, 1};
    vecs[7] = '{6, 6, 0, 3, 6, 6, 0};

    rst = 1'b1; en = 1'b0; fault = 1'b0;
    period = '0; duty = '0; dead_time = '0; ss_step = '0;
    #1;
    chk("rst_sw1", sw1, 0);
    chk("rst_sw2", sw2, 0);
    chk("rst_cycle_start", cycle_start, 0);
    chk("rst_ss_done", ss_done, 0);
    chk("rst_state", state, 0);

    // Steady-state widths over one period window
    for (int v = 0; v < 8; v++) begin
      start(vecs[v].p, vecs[v].d, vecs[v].dt, vecs[v].s);
      repeat (100) step();
      c1 = 0; c2 = 0; cs = 0;
      for (int i = 0; i < vecs[v].pe; i++) begin
        step();
        c1 += int'(sw1); c2 += int'(sw2); cs += int'(cycle_start);
      end
      chk($sformatf("vec%0d_sw1_width", v), c1, vecs[v].exp_sw1);
      chk($sformatf("vec%0d_sw2_width", v), c2, vecs[v].exp_sw2);
      chk($sformatf("vec%0d_cycle_start", v), cs, 1);
      chk($sformatf("vec%0d_state", v), state, 2);
      chk($sformatf("vec%0d_ss_done", v), ss_done, 1);
    end

    // Soft start ramp 1,2,3,4 then RUN after the 4th period
    start(10, 4, 0, 1);
    chk("ss_entry_state", state, 1);
    chk("ss_entry_cycle_start", cycle_start, 1);
    chk("ss_entry_ss_done", ss_done, 0);
    chk("ss_entry_sw1", sw1, 0);
    w = '{0, 0, 0, 0, 0, 0};
    for (int k = 1; k <= 60; k++) begin
      step();
      if (sw1) w[(k - 1) / 10]++;
      if (k == 39) chk("ss_state_before_wrap", state, 1);
      if (k == 40) begin
        chk("ss_state_after_wrap", state, 2);
        chk("ss_done_after_wrap", ss_done, 1);
      end
    end
    for (int j = 0; j < 6; j++) chk($sformatf("ss_width_%0d", j), w[j], exp_w[j]);

    // Duty change mid-period takes effect next period
    start(10, 5, 0, 5);
    repeat (20) step();
    wa = 0; wb = 0;
    for (int k = 21; k <= 40; k++) begin
      step();
      if (k == 23) duty = 16'd8;
      if (k <= 30) wa += int'(sw1);
      else wb += int'(sw1);
    end
    chk("shadow_cur_width", wa, 5);
    chk("shadow_next_width", wb, 8);

    // Fault latch and recovery
    start(10, 5, 0, 5);
    repeat (22) step();
    chk("pre_fault_sw1", sw1, 1);
    fault = 1'b1;
    step();
    chk("fault_sw1", sw1, 0);
    chk("fault_sw2", sw2, 0);
    chk("fault_state", state, 3);
    fault = 1'b0;
    repeat (3) step();
    chk("fault_held", state, 3);
    chk("fault_held_sw2", sw2, 0);
    en = 1'b0;
    step();
    chk("fault_to_idle", state, 0);
    ss_step = 16'd2;
    en = 1'b1;
    step();
    chk("restart_state", state, 1);
    c1 = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      c1 += int'(sw1);
    end
    chk("restart_ramp_width", c1, 2);

    // Asynchronous reset mid-period
    start(10, 5, 0, 5);
    repeat (22) step();
    chk("pre_rst_sw1", sw1, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_sw1", sw1, 0);
    chk("async_rst_sw2", sw2, 0);
    chk("async_rst_cycle_start", cycle_start, 0);
    chk("async_rst_state", state, 0);
    #2;
    rst = 1'b0;
    step();
    chk("post_rst_state", state, 1);
    chk("post_rst_cycle_start", cycle_start, 1);
    step();
    chk("post_rst_sw1", sw1, 1);

    chk("no_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
